// File: rtl/display_source_select_pkg.sv
// Shared encodings and seven-segment font for the display source selector.
package display_source_select_pkg;

    typedef enum logic [1:0] {
        MODE_SW    = 2'd0,
        MODE_PRESS = 2'd1,
        MODE_TICK  = 2'd2,
        MODE_ONES  = 2'd3
    } mode_e;

    // Active-low segments, bit order g..a, indexed by hex digit value.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_source_select_seg7_decode.sv
// One hex digit to active-low seven-segment pattern, purely combinational.
module seg7_decode
    import display_source_select_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int unsigned d = 0; d < 16; d++) begin
            if (nibble == 4'(d)) seg = SEG_FONT[d];
        end
    end

endmodule

// File: rtl/display_source_select.sv
// Selects switches, debounced press count, tick count or all-ones onto a
// registered multi-digit hex value and drives the matching seven-segment digits.
module display_source_select
    import display_source_select_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int PRESCALE_BITS   = 26,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   sw_value,
    input  logic                  key_n,
    input  logic [1:0]            mode,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   value,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  tick
);

    localparam int W    = 4 * DIGITS;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic                     key_meta;
    logic                     key_sync;
    logic                     key_level;
    logic [DB_W-1:0]          db_cnt;
    logic                     db_done;
    logic                     press_edge;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic [W-1:0]             press_count;
    logic [W-1:0]             tick_count;
    logic [W-1:0]             source;

    // The press is counted on the same edge the debounced level falls.
    assign db_done    = (key_sync != key_level) && (db_cnt == DB_LAST);
    assign press_edge = db_done && !key_sync;
    assign tick       = &prescaler;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            key_level <= 1'b1;
            db_cnt    <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            if (key_sync == key_level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                key_level <= key_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prescaler   <= '0;
            tick_count  <= '0;
            press_count <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_BITS'(1);
            if (tick)       tick_count  <= tick_count + W'(1);
            if (press_edge) press_count <= press_count + W'(1);
        end
    end

    always_comb begin
        source = '0;
        case (mode_e'(mode))
            MODE_SW:    source = sw_value;
            MODE_PRESS: source = press_count;
            MODE_TICK:  source = tick_count;
            MODE_ONES:  source = '1;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            value <= '0;
        end else if (!freeze) begin
            value <= source;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        seg7_decode u_seg7_decode (
            .nibble (value[4*i +: 4]),
            .seg    (hex[7*i +: 7])
        );
    end

endmodule
